// File: rtl/alu_pkg.sv
// Shared ALU packet definitions: opcodes, frame types, error-flag bit positions
// and the receiver state encoding.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } operation_t;

    typedef enum logic {
        PKT_DATA = 1'b0,
        PKT_CMD  = 1'b1
    } packet_type_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TYPE,
        ST_PAYLOAD,
        ST_STOP
    } rx_state_t;

    // Bit positions inside err_flags
    localparam int ERR_DATA = 2;
    localparam int ERR_CRC  = 1;
    localparam int ERR_OP   = 0;

    localparam logic [3:0] DATA_BYTES = 4'd8;
    localparam logic [3:0] CNT_SAT    = 4'd9;

    function automatic logic op_is_valid(input logic [2:0] code);
        case (code)
            OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_crc4_serial.sv
// Bit-serial CRC-4, polynomial x^4+x+1, initial value 0, MSB-first input.
module alu_crc4_serial (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    input  logic       din,
    output logic [3:0] crc
);

    logic fb;

    assign fb = crc[3] ^ din;

    // Shift one message bit per enabled cycle; clear wins over enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 4'b0000;
        end else if (clear) begin
            crc <= 4'b0000;
        end else if (enable) begin
            crc <= {crc[2], crc[1], crc[0] ^ fb, fb};
        end
    end

endmodule

// File: rtl/alu_serial_rx.sv
// Serial ALU packet receiver: 11-bit frames (start, type, 8 payload MSB first,
// stop), eight data bytes then one cmd byte form a packet {B, A, OP, CRC}.
// Optional CRC check: define ALU_RX_CRC_CHECK_EN to build the CRC engine.
module alu_serial_rx
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    input  logic        pkt_ready,
    output logic        pkt_valid,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [2:0]  op,
    output logic [2:0]  err_flags,
    output logic        overrun
);

    rx_state_t    state, state_nxt;
    logic         armed;
    packet_type_t ptype;
    logic [2:0]   bit_cnt;
    logic [7:0]   pay_sr;
    logic [63:0]  data_sr;
    logic [3:0]   byte_cnt;
    logic         pkt_done;
    logic         crc_bad;
    logic [2:0]   err_nxt;

    // A packet completes on any cmd stop bit, or on a broken data-frame stop bit
    assign pkt_done = (state == ST_STOP) && (ptype == PKT_CMD || !sin);

`ifdef ALU_RX_CRC_CHECK_EN
    logic       crc_en;
    logic       crc_din;
    logic [3:0] crc_val;

    // Data bytes feed all 8 bits; cmd bytes feed only {1, OP}, never the CRC field
    assign crc_en  = (state == ST_PAYLOAD) && (ptype == PKT_DATA || bit_cnt < 3'd4);
    assign crc_din = (ptype == PKT_CMD && bit_cnt == 3'd0) ? 1'b1 : sin;

    alu_crc4_serial u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (pkt_done),
        .enable (crc_en),
        .din    (crc_din),
        .crc    (crc_val)
    );

    assign crc_bad = (crc_val != pay_sr[3:0]);
`else
    assign crc_bad = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: a start bit is ignored until one clock after reset release
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (armed && !sin) state_nxt = ST_TYPE;
            ST_TYPE:    state_nxt = ST_PAYLOAD;
            ST_PAYLOAD: if (bit_cnt == 3'd7) state_nxt = ST_STOP;
            ST_STOP:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Frame datapath: payload shift, data-byte accumulation and byte counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed    <= 1'b0;
            ptype    <= PKT_DATA;
            bit_cnt  <= 3'd0;
            pay_sr   <= 8'd0;
            data_sr  <= 64'd0;
            byte_cnt <= 4'd0;
        end else begin
            armed <= 1'b1;
            case (state)
                ST_TYPE: begin
                    ptype   <= packet_type_t'(sin);
                    bit_cnt <= 3'd0;
                end
                ST_PAYLOAD: begin
                    pay_sr  <= {pay_sr[6:0], sin};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                ST_STOP: begin
                    if (!sin || ptype == PKT_CMD) begin
                        byte_cnt <= 4'd0;
                    end else begin
                        data_sr <= {data_sr[55:0], pay_sr};
                        if (byte_cnt != CNT_SAT) byte_cnt <= byte_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Error classification with exclusive priority DATA > CRC > OP
    always_comb begin
        err_nxt = 3'b000;
        if (!sin || byte_cnt != DATA_BYTES) err_nxt[ERR_DATA] = 1'b1;
        else if (crc_bad)                   err_nxt[ERR_CRC]  = 1'b1;
        else if (!op_is_valid(pay_sr[6:4])) err_nxt[ERR_OP]   = 1'b1;
    end

    // Output packet register with valid/ready hold and overrun on a dropped packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_valid <= 1'b0;
            a         <= 32'd0;
            b         <= 32'd0;
            op        <= 3'd0;
            err_flags <= 3'd0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (pkt_done && (!pkt_valid || pkt_ready)) begin
                pkt_valid <= 1'b1;
                a         <= data_sr[31:0];
                b         <= data_sr[63:32];
                op        <= pay_sr[6:4];
                err_flags <= err_nxt;
            end else if (pkt_done) begin
                overrun <= 1'b1;
            end else if (pkt_ready) begin
                pkt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_serial_rx.md
ALU_SERIAL_RX -- requirements
Module: alu_serial_rx

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-003 SHALL have port sin, input, 1: serial line, idle high, one bit per clk.
REQ-004 SHALL have port pkt_ready, input, 1: consumer accepts the packet.
REQ-005 SHALL have port pkt_valid, output, 1: packet available.
REQ-006 SHALL have port a, output, 32: operand A.
REQ-007 SHALL have port b, output, 32: operand B.
REQ-008 SHALL have port op, output, 3: operation code.
REQ-009 SHALL have port err_flags, output, 3: [2] ERR_DATA, [1] ERR_CRC, [0] ERR_OP.
REQ-010 SHALL have port overrun, output, 1: one-cycle pulse when a completed packet is dropped.

Function
REQ-011 SHALL receive frames of 11 bits: start 0, type bit (0 data, 1 cmd), 8 payload bits MSB first, stop 1.
REQ-012 SHALL use FSM IDLE->TYPE->PAYLOAD(8 cycles)->STOP->IDLE, leaving IDLE when sin is sampled 0.
REQ-013 SHALL build the packet from 8 data bytes (B[31:24]..B[7:0], then A[31:24]..A[7:0]) followed by one cmd byte {0, OP[2:0], CRC[3:0]}.
REQ-014 SHALL check CRC-4, polynomial x^4+x+1, initial 0000, over the 68-bit message {B, A, 1'b1, OP}, MSB first.
REQ-015 SHALL feed CRC bit-serially as payload bits arrive, substituting constant 1 for cmd bit 7.
REQ-016 SHALL accept only opcodes 000 AND, 001 OR, 100 ADD, 101 SUB as valid.
REQ-017 SHALL set err_flags with exclusive priority: data-byte count != 8 or stop bit 0 -> 100; else CRC mismatch -> 010; else invalid op -> 001; else 000.
REQ-018 SHALL abandon a frame whose stop bit is 0 as ERR_DATA, emit an error packet, and clear the byte count.
REQ-019 SHALL saturate the data-byte counter at 9 when surplus data bytes arrive.
REQ-020 SHALL assert pkt_valid on the clock after the cmd-byte stop bit is sampled.
REQ-021 SHALL hold pkt_valid, a, b, op, err_flags stable until the cycle pkt_valid && pkt_ready.
REQ-022 SHALL deassert pkt_valid in the cycle after pkt_valid && pkt_ready, unless a new packet completes in that same cycle.
REQ-023 SHALL load a new packet and keep pkt_valid high when a new packet completes in the pkt_valid && pkt_ready cycle.
REQ-024 SHALL, when a packet completes while pkt_valid && !pkt_ready, keep the held packet, drop the new one, and pulse overrun.
REQ-025 SHALL reset the byte counter and CRC after each cmd byte, valid or erroneous.

Reset
REQ-026 SHALL, on rst_n low, force FSM to IDLE, clear counters and CRC, and zero pkt_valid, a, b, op, err_flags, overrun.
REQ-027 SHALL discard any partially received frame on reset mid-frame and emit no packet for it.
REQ-028 SHALL treat sin as idle for one clock after reset release.

Configuration
REQ-029 SHALL, with ALU_RX_CRC_CHECK_EN defined, instantiate the CRC engine and perform the REQ-014 check.
REQ-030 SHALL, without ALU_RX_CRC_CHECK_EN, omit the CRC engine, ignore received CRC bits, and never set err_flags[1].

Structure
REQ-031 SHALL take operation_t, packet_type_t and ERR_DATA/ERR_CRC/ERR_OP bit constants from the shared alu_pkg.
REQ-032 SHALL implement CRC in sub-module alu_crc4_serial (clear, enable, data bit in, 4-bit crc out).

Verification
REQ-033 SHALL cover: ADD, A=1, B=2, correct CRC -> pkt_valid 1 clk after stop, a=1, b=2, op=100, err_flags=000.
REQ-034 SHALL cover: AND, A=0xFFFF0000, B=0x0F0F0F0F, CRC bit 0 inverted -> err_flags=010 with macro, 000 without.
REQ-035 SHALL cover: 3 data bytes then cmd byte -> err_flags=100; a following correct SUB packet decodes with err_flags=000.
REQ-036 SHALL cover: op=011 with matching CRC -> err_flags=001.
REQ-037 SHALL cover: pkt_ready held 0 across two OR packets -> first packet retained, overrun pulses once; pkt_ready=1 -> pkt_valid drops next clk.
REQ-038 SHALL cover: rst_n low during byte 5 -> all outputs 0, no packet emitted; next full packet decodes correctly.
